// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package mul_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    CALC,
    NEG_LO,
    NEG_HI,
    DONE
  } mul_state_t;

  localparam int MUL_ITER    = 32;
  localparam int MUL_LATENCY = 36;
  localparam int CNT_W       = 5;
endpackage

// File: rtl/add_32.sv
// 32-bit ripple-carry adder with carry-out and signed-overflow flag.
module add_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);
  logic [32:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[32];
  assign ovf  = c[31] ^ c[32];
endmodule

// File: rtl/mul_seq_32.sv
// Radix-2 shift-add multiplier, 32x32->64, signed or unsigned, fixed latency.
// One shared adder handles operand absolute value, accumulation and final negation.
module mul_seq_32
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_result
);
  mul_state_t state, state_next;

  logic [31:0]      mcand;
  logic [31:0]      lo;
  logic [31:0]      acc_hi;
  logic [CNT_W-1:0] cnt;
  logic             sgn;
  logic             neg;
  logic             carry;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout, add_ovf_unused;
  logic        accept;

  add_32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf_unused)
  );

  assign accept = ((state == IDLE) || (state == DONE)) && i_start;
  assign o_done = (state == DONE);
  assign o_busy = (state == ABS_A) || (state == ABS_B) || (state == CALC) ||
                  (state == NEG_LO) || (state == NEG_HI);

  // Adder operands: negation is ~x + cin, accumulation is acc_hi + partial product.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ABS_A:  begin add_a = ~mcand;  add_cin = 1'b1;  end
      ABS_B:  begin add_a = ~lo;     add_cin = 1'b1;  end
      CALC:   begin add_a = acc_hi;  add_b = lo[0] ? mcand : '0; end
      NEG_LO: begin add_a = ~lo;     add_cin = 1'b1;  end
      NEG_HI: begin add_a = ~acc_hi; add_cin = carry; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = ABS_A;
      ABS_A:   state_next = ABS_B;
      ABS_B:   state_next = CALC;
      CALC:    if (cnt == CNT_W'(MUL_ITER - 1)) state_next = NEG_LO;
      NEG_LO:  state_next = NEG_HI;
      NEG_HI:  state_next = DONE;
      DONE:    state_next = i_start ? ABS_A : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      neg      <= 1'b0;
      carry    <= 1'b0;
      o_result <= '0;
    end else if (accept) begin
      mcand <= a;
      lo    <= b;
      sgn   <= i_signed;
      neg   <= i_signed & (a[31] ^ b[31]);
    end else begin
      case (state)
        ABS_A: if (sgn && mcand[31]) mcand <= add_sum;
        ABS_B: begin
          if (sgn && lo[31]) lo <= add_sum;
          acc_hi <= '0;
          cnt    <= '0;
        end
        CALC: begin
          {acc_hi, lo} <= {add_cout, add_sum, lo[31:1]};
          cnt          <= cnt + 1'b1;
        end
        NEG_LO: begin
          if (neg) begin
            lo    <= add_sum;
            carry <= add_cout;
          end else begin
            carry <= 1'b0;
          end
        end
        NEG_HI: begin
          if (neg) begin
            acc_hi   <= add_sum;
            o_result <= {add_sum, lo};
          end else begin
            o_result <= {acc_hi, lo};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: the driver queues expected products, a monitor checks each o_done.
module tb_mul_seq_32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        o_busy, o_done;
  logic [63:0] o_result;

  typedef struct {
    logic [63:0] res;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   prev_done_cyc = -1;
  int   last_done_cyc = -1;

  mul_seq_32 dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_signed (i_signed),
    .a        (a),
    .b        (b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check64({e.name, "_result"}, o_result, e.res);
        check64({e.name, "_latency"}, 64'(cyc - e.acc), 64'd36);
        check64({e.name, "_busy_in_done"}, {63'd0, o_busy}, 64'd0);
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        $display("[TB] %s: result=%h latency=%0d", e.name, o_result, cyc - e.acc);
      end
    end
  end

  // Drive a request at the current negedge; the following posedge accepts it.
  task automatic issue(input string name, input logic sg, input logic [31:0] av,
                       input logic [31:0] bv, input logic [63:0] exp_res);
    exp_t e;
    i_start  = 1'b1;
    i_signed = sg;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    e.res  = exp_res;
    e.acc  = cyc;
    e.name = name;
    sb.push_back(e);
    i_start = 1'b0;
    check64({name, "_busy_after_accept"}, {63'd0, o_busy}, 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 80);
    if (!o_done) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check64("reset_result", o_result, 64'd0);
    check64("reset_flags", {62'd0, o_busy, o_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue("u_7x6", 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    wait_done("u_7x6");
    @(negedge clk);
    issue("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("s_m3x5");
    @(negedge clk);
    issue("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("u_max_sq");
    @(negedge clk);
    issue("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done("s_min_sq");
    @(negedge clk);
    issue("s_min_x1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    wait_done("s_min_x1");
    @(negedge clk);
    issue("s_m7xm6", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A);
    wait_done("s_m7xm6");
    @(negedge clk);
    issue("s_0xm5", 1'b1, 32'd0, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000);
    wait_done("s_0xm5");
    @(negedge clk);
    issue("u_80000000x2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_done("u_80000000x2");
    @(negedge clk);

    // A start pulse while busy must be dropped without disturbing the running op.
    issue("ign_1234x10", 1'b0, 32'd1234, 32'd10, 64'd12340);
    repeat (9) @(negedge clk);
    i_start = 1'b1; i_signed = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("ign_1234x10");
    repeat (5) @(negedge clk);
    check64("result_hold", o_result, 64'd12340);

    // Asynchronous abort mid-operation.
    issue("abort_100x100", 1'b0, 32'd100, 32'd100, 64'd10000);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check64("async_rst_result", o_result, 64'd0);
    check64("async_rst_flags", {62'd0, o_busy, o_done}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("post_rst_9x9", 1'b0, 32'd9, 32'd9, 64'd81);
    wait_done("post_rst_9x9");
    @(negedge clk);

    // Back-to-back: new start presented in the DONE cycle.
    issue("b2b_12x12", 1'b0, 32'd12, 32'd12, 64'd144);
    wait_done("b2b_12x12");
    issue("b2b_3x3", 1'b0, 32'd3, 32'd3, 64'd9);
    wait_done("b2b_3x3");
    @(negedge clk);
    check64("b2b_done_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd37);

    repeat (3) @(negedge clk);
    check64("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
Iterative radix-2 shift-add multiplier: 32x32 -> 64-bit, signed or unsigned.
It consumes the existing add_32 ripple adder, which is instantiated once and time-shared for absolute value, partial-product accumulation and final negation.
It sits beside the ALU datapath as the multi-cycle MUL unit, using a start/busy/done handshake.
Latency is fixed, so the scheduler can count cycles.

Parameters:
None. Width is fixed at 32; internal constants come from the shared package.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
i_start  input  1  request; sampled only in IDLE or DONE
i_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with i_start
a  input  32  multiplicand; sampled with i_start
b  input  32  multiplier; sampled with i_start
o_busy  output  1  high from the accepting edge until DONE is entered
o_done  output  1  single-cycle pulse; o_result valid
o_result  output  64  product; holds its value until the next accepted start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; o_busy=0, o_done=0, o_result=0; all internal registers 0.
  - Reset mid-operation aborts immediately; no partial result escapes.
- States: IDLE, ABS_A, ABS_B, CALC, NEG_LO, NEG_HI, DONE.
- Acceptance: the edge where state is IDLE or DONE and i_start=1.
  - Latch a, b, i_signed.
  - Compute neg = i_signed & (a[31]^b[31]).
  - Go to ABS_A.
  - i_start in any other state is ignored (no queueing).
- ABS_A:
  - If signed and a[31]=1: mcand = add_32(~a, 0, cin=1). Otherwise mcand = a.
  - -2^31 yields 0x8000_0000, which is correct as unsigned.
- ABS_B: same rule for b into register lo.
  - Clear acc_hi=0 and the 5-bit iteration counter cnt=0.
- CALC (exactly 32 cycles):
  - {c, s} = add_32(acc_hi, lo[0] ? mcand : 0, cin=0).
  - {acc_hi, lo} <= {c, s, lo[31:1]}.
  - cnt++. Leave CALC when cnt==31.
- NEG_LO:
  - If neg: lo <= ~lo + 1 via add_32 and save the carry.
  - Otherwise pass through with saved carry 0.
- NEG_HI:
  - If neg: acc_hi <= add_32(~acc_hi, 0, saved carry).
  - Then load o_result = {acc_hi', lo} and go to DONE.
- DONE: o_done=1 and o_busy=0 for one cycle.
  - Go to IDLE, or to ABS_A if i_start=1 (back-to-back).
- Latency:
  - o_done is high in the cycle following the 36th rising edge after the accepting edge.
  - Latency is identical for signed and unsigned operation.
- o_busy is high in ABS_A..NEG_HI.
- Adder overflow output is unused. The adder b-input and cin are muxed by state.
- Unsigned products never overflow 64 bits. Signed products are exact, including (-2^31)*(-2^31) = 2^62.

Decomposition:
- Package mul_pkg:
  - state enum mul_state_t.
  - MUL_ITER=32, MUL_LATENCY=36, CNT_W=5.
- One sub-module: the existing add_32, instantiated once as u_add. It is not duplicated per step.
- Operand/carry-in muxing, FSM and registers stay in mul_seq_32.

Test Plan:
- Unsigned 7*6, i_signed=0 -> o_done exactly 36 edges after accept; o_result=0x0000_0000_0000_002A; o_busy low in the DONE cycle.
- Signed -3*5 (a=0xFFFF_FFFD, b=5) -> o_result=0xFFFF_FFFF_FFFF_FFF1.
- Unsigned 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001.
- Signed 0x8000_0000*0x8000_0000 -> 0x4000_0000_0000_0000.
- Signed 0x8000_0000*1 -> 0xFFFF_FFFF_8000_0000.
- Pulse i_start with new operands at cycle 10 of a busy op -> ignored; first result unchanged and latency unchanged.
- Assert rst at cycle 12 of an op -> outputs 0 asynchronously; a new 9*9 after release gives 81 with full latency.
- Assert i_start in the DONE cycle (12*12 followed by 3*3) -> second op accepted back-to-back; results 144 then 9, with o_done pulses 37 cycles apart.
